cordic_vec_angle: RTL

- Iterative vectoring-mode CORDIC. It sits directly upstream of the vector rotation PEs (VEC_PE / VEC_CORDIC_VR).
- Accepts one (X, Y) pair. Runs 14 micro-rotations that drive Y to zero.
- Emits the 14-bit micro-rotation direction word consumed as angle_d0_i/angle_d1_i, plus the K-compensated magnitude.
- Direction-bit convention matches the rotation stage exactly, so that stage can replay the same rotation on other vector pairs.

---
 rtl/cordic_vec_angle.sv | 124 ++++++++++++
 1 files changed

// File: rtl/cordic_vec_angle.sv
// rtl/cordic_vec_angle.sv - iterative vectoring CORDIC producing direction word and scaled magnitude
module cordic_vec_angle #(
    parameter int BITWIDTH   = 18,
    parameter int CORDIC_NUM = 14
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [BITWIDTH-1:0]  X_i,
    input  logic signed [BITWIDTH-1:0]  Y_i,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [CORDIC_NUM-1:0]       d_o,
    output logic                        neg_o,
    output logic signed [BITWIDTH-1:0]  mag_o
);

    localparam int W  = BITWIDTH + 2;
    localparam int PW = W + 16;
    localparam int CW = $clog2(CORDIC_NUM);
    localparam logic [14:0]           K       = 15'b010011011011101;
    localparam logic [CW-1:0]         LAST    = CW'(CORDIC_NUM - 1);
    localparam logic signed [PW-1:0]  MAG_MAX = PW'((64'sd1 <<< (BITWIDTH - 1)) - 1);

    typedef enum logic [1:0] {IDLE, ITER, SCALE, DONE} state_t;

    state_t                 state, state_nx;
    logic signed [W-1:0]    xr, yr, x_in, y_in, xs, ys;
    logic [CW-1:0]          cnt;
    logic [CORDIC_NUM-1:0]  d;
    logic signed [PW-1:0]   prod, mag_full;
    logic signed [BITWIDTH-1:0] mag_sat;
    logic                   accept;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;

    // Guard bits make negating the most negative input exact.
    assign x_in = W'(X_i);
    assign y_in = W'(Y_i);
    assign xs   = xr >>> cnt;
    assign ys   = yr >>> cnt;
    assign prod = xr * $signed({1'b0, K});
    assign mag_full = prod >>> 14;

    always_comb begin
        mag_sat = mag_full[BITWIDTH-1:0];
        if (mag_full > MAG_MAX) begin
            mag_sat = {1'b0, {(BITWIDTH-1){1'b1}}};
        end else if (mag_full < 0) begin
            mag_sat = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = ITER;
            ITER:    if (cnt == LAST) state_nx = SCALE;
            SCALE:   state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xr    <= '0;
            yr    <= '0;
            cnt   <= '0;
            d     <= '0;
            d_o   <= '0;
            neg_o <= 1'b0;
            mag_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt <= '0;
                        d   <= '0;
                        if (X_i[BITWIDTH-1]) begin
                            xr    <= -x_in;
                            yr    <= -y_in;
                            neg_o <= 1'b1;
                        end else begin
                            xr    <= x_in;
                            yr    <= y_in;
                            neg_o <= 1'b0;
                        end
                    end
                end
                ITER: begin
                    // d=1 mirrors the rotation stage: X -= Y>>i, Y += X>>i.
                    if (yr[W-1]) begin
                        d[cnt] <= 1'b1;
                        xr     <= xr - ys;
                        yr     <= yr + xs;
                    end else begin
                        d[cnt] <= 1'b0;
                        xr     <= xr + ys;
                        yr     <= yr - xs;
                    end
                    cnt <= cnt + 1'b1;
                end
                SCALE: begin
                    mag_o <= mag_sat;
                    d_o   <= d;
                end
                default: ;
            endcase
        end
    end

endmodule
